hc800_ram_bridge: RTL and testbench
===================================

// Module: hc800_ram_bridge
// PURPOSE
//  Sits between the HC800 8-bit RAM bus (io_ramBus_*) and the 16-bit SDRAM controller (addr/din/we/oe/ds/dout).
//  Turns byte accesses into word accesses and selects the byte lane.
//  Holds each SDRAM request stable for a fixed latency and reports completion to the master with a ready pulse.
//  Keeps a one-word read cache so that sequential byte reads in the same word bypass SDRAM.
// PARAMETERS
//  ADDR_W      21  byte address width on the HC800 side; the SDRAM word address is ADDR_W-1 bits
//  SD_LATENCY  4   clk_sys cycles that oe/we are held before sd_dout is valid or the write has landed (>=1)
// PORTS
//  clk_sys        in   1         bus clock (13.5 MHz domain)
//  reset          in   1         asynchronous, active-high
//  bus_enable     in   1         request valid; master holds address/data until bus_ready
//  bus_write      in   1         1 = write, 0 = read
//  bus_address    in   ADDR_W    byte address
//  bus_wdata      in   8         write byte
//  bus_rdata      out  8         read byte (registered)
//  bus_ready      out  1         one-cycle completion pulse
//  cache_inval    in   1         drop the cached word (upload or external SDRAM writer)
//  sd_addr        out  ADDR_W-1  SDRAM word address = bus_address[ADDR_W-1:1]
//  sd_din         out  16        {bus_wdata, bus_wdata}
//  sd_we          out  1         SDRAM write strobe
//  sd_oe          out  1         SDRAM access strobe (high for both reads and writes)
//  sd_ds          out  2         lane select: [1] = high byte (addr[0]=1), [0] = low byte
//  sd_dout        in   16        SDRAM read word
// BEHAVIOUR
//  Reset values
//   - All outputs 0; state is IDLE; counter is 0; cache_valid is 0.
//   - Reset mid-access drops sd_oe and sd_we immediately; no ready pulse is issued.
//  States: IDLE, ACCESS, DONE
//   - IDLE, bus_enable=1, read, cache hit (cache_valid and tag==addr[ADDR_W-1:1]):
//     go to DONE; bus_rdata gets the cached lane. No SDRAM strobes.
//   - IDLE, bus_enable=1, any other request:
//     latch address, data and direction; go to ACCESS with cnt=SD_LATENCY-1.
//   - ACCESS: strobes are driven from the latched request (the registers, not bus_* live):
//     - read:  sd_oe=1, sd_we=0, sd_ds=2'b11
//     - write: sd_oe=1, sd_we=1, sd_ds=one-hot lane
//     - cnt decrements each cycle; at cnt==0 go to DONE, drop strobes, and on a read capture sd_dout.
//   - DONE: bus_ready=1 for exactly one cycle, then IDLE.
//     IDLE never samples bus_enable in the same cycle that DONE is active.
//   - Latency:
//     - cache hit: bus_ready 1 cycle after the accepting edge
//     - miss or write: bus_ready SD_LATENCY+1 cycles after the accepting edge
//  Data and lanes
//   - Lane = bus_address[0]. Read byte = lane ? word[15:8] : word[7:0].
//   - bus_rdata is registered and forced to 8'h00 on every cycle where bus_enable is 0 (OR-bus convention).
//     Otherwise it holds its last value until the next completion.
//  Cache
//   - A read miss fills the tag and the full word, and sets cache_valid.
//   - A write whose tag matches updates only the written lane in the cache. A write miss leaves the cache untouched.
//   - cache_inval clears cache_valid on the next edge.
//     - Inval in the same cycle as a fill: inval wins, cache_valid ends at 0.
//     - Inval during ACCESS does not abort the access.
//  Boundaries
//   - Address wrap: the top word 0x0FFFFF is valid; there is no carry into other logic.
//   - bus_enable dropped during ACCESS: the access completes; the ready pulse is still issued and ignored.
// STRUCTURE
//  - Shared header hc800_ram_defs.vh: state encodings, LANE_LO/LANE_HI ds constants.
//  - Counter width is $clog2(SD_LATENCY+1).
//  - One sub-module is natural: hc800_ram_word_cache (tag, valid, word, hit compare, lane update).
//  - The FSM and strobe registers stay in this module.
// TESTING (SD_LATENCY=4; the SDRAM model returns a fixed sd_dout per word address)
//  1. Write 0xA5 to 0x00011:
//     - sd_addr=0x00008, ds=2'b10, din=0xA5A5, we=oe=1 for exactly 4 cycles
//     - bus_ready pulses 5 cycles after accept; cache stays invalid.
//  2. Read 0x00010 with model word 0x1234 -> 4-cycle oe, bus_rdata=0x34, ready at +5.
//     Then read 0x00011 -> bus_rdata=0x12, ready at +1, sd_oe never rises.
//  3. After test 2, write 0xFF to 0x00011, then read 0x00011 -> bus_rdata=0xFF via hit.
//     The write itself produced 4 cycles of we.
//  4. Pulse cache_inval, then read 0x00010 -> full 4-cycle SDRAM read (miss).
//     Inval on the fill cycle -> the next read also misses.
//  5. Assert reset at cycle 2 of ACCESS:
//     - oe/we/ready/rdata are 0 asynchronously, with no ready pulse.
//     - After release, a read of the previously cached word misses.
//  6. Hold bus_enable=0 after a completed read of 0x34 -> bus_rdata=0x00 on the next edge.
//     Back-to-back requests -> no request is issued twice.

Source files
------------

// File: rtl/hc800_ram_bridge_pkg.sv
// HC800 RAM bridge shared types.
// FSM states, SDRAM lane masks and lane helpers.
package hc800_ram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] LANE_LO   = 2'b01;
  localparam logic [1:0] LANE_HI   = 2'b10;
  localparam logic [1:0] LANE_BOTH = 2'b11;

  function automatic logic [7:0] lane_byte(
    input logic [15:0] w,
    input logic        hi
  );
    return hi ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [1:0] lane_ds(
    input logic hi
  );
    return hi ? LANE_HI : LANE_LO;
  endfunction

endpackage

// File: rtl/hc800_ram_word_cache.sv
// One-word read cache for the HC800 RAM bridge.
// Tag/valid/word storage with hit compare and byte-lane update.
module hc800_ram_word_cache #(
  parameter int TAG_W = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inval,
  input  logic [TAG_W-1:0] i_look_tag,
  output logic             o_hit,
  output logic [15:0]      o_word,
  input  logic             i_fill,
  input  logic [TAG_W-1:0] i_fill_tag,
  input  logic [15:0]      i_fill_word,
  input  logic             i_wr,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic             i_wr_hi,
  input  logic [7:0]       i_wr_byte
);

  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [15:0]      r_word;
  logic             w_wr_hit;

  assign w_wr_hit = i_wr && r_valid && (r_tag == i_wr_tag);
  assign o_hit    = r_valid && (r_tag == i_look_tag);
  assign o_word   = r_word;

  // Invalidate beats a fill landing on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_word  <= '0;
    end else begin
      if (i_inval)
        r_valid <= 1'b0;
      else if (i_fill)
        r_valid <= 1'b1;
      if (i_fill) begin
        r_tag  <= i_fill_tag;
        r_word <= i_fill_word;
      end else if (w_wr_hit) begin
        if (i_wr_hi)
          r_word[15:8] <= i_wr_byte;
        else
          r_word[7:0]  <= i_wr_byte;
      end
    end
  end

endmodule

// File: rtl/hc800_ram_bridge.sv
// HC800 8-bit RAM bus to 16-bit SDRAM bridge.
// Fixed-latency strobes, ready pulse and a one-word read cache.
module hc800_ram_bridge
  import hc800_ram_bridge_pkg::*;
#(
  parameter int ADDR_W     = 21,
  parameter int SD_LATENCY = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              bus_enable,
  input  logic              bus_write,
  input  logic [ADDR_W-1:0] bus_address,
  input  logic [7:0]        bus_wdata,
  output logic [7:0]        bus_rdata,
  output logic              bus_ready,
  input  logic              cache_inval,
  output logic [ADDR_W-2:0] sd_addr,
  output logic [15:0]       sd_din,
  output logic              sd_we,
  output logic              sd_oe,
  output logic [1:0]        sd_ds,
  input  logic [15:0]       sd_dout
);

  localparam int CW = $clog2(SD_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SD_LATENCY - 1);

  state_t            r_state;
  state_t            w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-2:0] r_addr;
  logic              r_lane;
  logic              r_wr;
  logic [7:0]        r_wdata;
  logic              r_oe;
  logic              r_we;
  logic [1:0]        r_ds;
  logic [7:0]        r_rdata;

  logic              w_hit;
  logic [15:0]       w_cword;
  logic              w_hit_acc;
  logic              w_miss_acc;
  logic              w_finish;
  logic [ADDR_W-2:0] w_tag;

  assign w_tag = bus_address[ADDR_W-1:1];

  hc800_ram_word_cache #(
    .TAG_W (ADDR_W-1)
  ) u_cache (
    .i_clk       (clk_sys),
    .i_rst       (reset),
    .i_inval     (cache_inval),
    .i_look_tag  (w_tag),
    .o_hit       (w_hit),
    .o_word      (w_cword),
    .i_fill      (w_finish && !r_wr),
    .i_fill_tag  (r_addr),
    .i_fill_word (sd_dout),
    .i_wr        (w_finish && r_wr),
    .i_wr_tag    (r_addr),
    .i_wr_hi     (r_lane),
    .i_wr_byte   (r_wdata)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_hit_acc  = 1'b0;
    w_miss_acc = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus_enable) begin
          if (!bus_write && w_hit) begin
            w_hit_acc  = 1'b1;
            w_state_nx = ST_DONE;
          end else begin
            w_miss_acc = 1'b1;
            w_state_nx = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (r_cnt == '0) begin
          w_finish   = 1'b1;
          w_state_nx = ST_DONE;
        end
      end
      ST_DONE:  w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // Strobes are latched at accept so ACCESS never follows live bus pins.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_lane  <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_oe    <= 1'b0;
      r_we    <= 1'b0;
      r_ds    <= '0;
    end else if (w_miss_acc) begin
      r_cnt   <= CNT_LOAD;
      r_addr  <= w_tag;
      r_lane  <= bus_address[0];
      r_wr    <= bus_write;
      r_wdata <= bus_wdata;
      r_oe    <= 1'b1;
      r_we    <= bus_write;
      r_ds    <= bus_write ? lane_ds(bus_address[0]) : LANE_BOTH;
    end else if (w_finish) begin
      r_oe <= 1'b0;
      r_we <= 1'b0;
      r_ds <= '0;
    end else if (r_state == ST_ACCESS) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Idle bus reads back zero so several slaves can be OR-ed together.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      r_rdata <= '0;
    else if (!bus_enable)
      r_rdata <= '0;
    else if (w_hit_acc)
      r_rdata <= lane_byte(w_cword, bus_address[0]);
    else if (w_finish && !r_wr)
      r_rdata <= lane_byte(sd_dout, r_lane);
  end

  assign bus_rdata = r_rdata;
  assign bus_ready = (r_state == ST_DONE);
  assign sd_addr   = r_addr;
  assign sd_din    = {r_wdata, r_wdata};
  assign sd_we     = r_we;
  assign sd_oe     = r_oe;
  assign sd_ds     = r_ds;

endmodule

// File: tb/tb_hc800_ram_bridge.sv
// Directed self-checking bench for hc800_ram_bridge.
// SDRAM model returns a fixed word per word address.
module tb_hc800_ram_bridge;

  logic        clk_sys;
  logic        reset;
  logic        bus_enable;
  logic        bus_write;
  logic [20:0] bus_address;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ready;
  logic        cache_inval;
  logic [19:0] sd_addr;
  logic [15:0] sd_din;
  logic        sd_we;
  logic        sd_oe;
  logic [1:0]  sd_ds;
  logic [15:0] sd_dout;

  int n_chk  = 0;
  int n_fail = 0;
  int n_oe   = 0;
  int n_rdy  = 0;

  hc800_ram_bridge #(
    .ADDR_W     (21),
    .SD_LATENCY (4)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .bus_enable  (bus_enable),
    .bus_write   (bus_write),
    .bus_address (bus_address),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ready   (bus_ready),
    .cache_inval (cache_inval),
    .sd_addr     (sd_addr),
    .sd_din      (sd_din),
    .sd_we       (sd_we),
    .sd_oe       (sd_oe),
    .sd_ds       (sd_ds),
    .sd_dout     (sd_dout)
  );

  assign sd_dout = (sd_addr == 20'h00008) ? 16'h1234
                                          : {4'hC, sd_addr[11:0]};

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(posedge sd_oe) n_oe++;
  always @(posedge bus_ready) n_rdy++;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic wr, input logic [20:0] a,
                     input logic [7:0] d, input bit keep,
                     input int inval_at,
                     output int lat, output int oe_n, output int we_n,
                     output logic [7:0] rd, output logic [1:0] ds,
                     output logic [19:0] sa, output logic [15:0] din);
    bus_enable  = 1'b1;
    bus_write   = wr;
    bus_address = a;
    bus_wdata   = d;
    lat  = 0;
    oe_n = 0;
    we_n = 0;
    rd   = '0;
    ds   = '0;
    sa   = '0;
    din  = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      cache_inval = 1'b0;
      if (sd_oe) begin
        oe_n++;
        ds  = sd_ds;
        sa  = sd_addr;
        din = sd_din;
      end
      if (sd_we) we_n++;
      if (bus_ready) begin
        lat = k;
        rd  = bus_rdata;
        break;
      end
      if (k == inval_at) cache_inval = 1'b1;
    end
    if (!keep) begin
      bus_enable = 1'b0;
      tick();
    end
  endtask

  initial begin
    int lat, oe_n, we_n, oe0, rdy0;
    logic [7:0]  rd;
    logic [1:0]  ds;
    logic [19:0] sa;
    logic [15:0] din;

    reset       = 1'b1;
    bus_enable  = 1'b0;
    bus_write   = 1'b0;
    bus_address = '0;
    bus_wdata   = '0;
    cache_inval = 1'b0;
    tick();
    tick();
    chk("rst_ready", bus_ready, 0);
    chk("rst_oe", sd_oe, 0);
    chk("rst_we", sd_we, 0);
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_addr", sd_addr, 0);
    reset = 1'b0;
    tick();

    // 1: write miss
    req(1, 21'h00011, 8'hA5, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t1_lat", lat, 5);
    chk("t1_we", we_n, 4);
    chk("t1_oe", oe_n, 4);
    chk("t1_ds", ds, 2'b10);
    chk("t1_addr", sa, 20'h00008);
    chk("t1_din", din, 16'hA5A5);

    // 2: read miss then same-word hit
    req(0, 21'h00010, 8'h00, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t2_lat", lat, 5);
    chk("t2_oe", oe_n, 4);
    chk("t2_ds", ds, 2'b11);
    chk("t2_rd", rd, 8'h34);
    chk("t2_we", we_n, 0);
    req(0, 21'h00011, 8'h00, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t2h_lat", lat, 1);
    chk("t2h_oe", oe_n, 0);
    chk("t2h_rd", rd, 8'h12);

    // 3: write hit updates one lane
    req(1, 21'h00011, 8'hFF, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t3_we", we_n, 4);
    chk("t3_ds", ds, 2'b10);
    req(0, 21'h00011, 8'h00, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t3h_lat", lat, 1);
    chk("t3h_rd", rd, 8'hFF);
    req(0, 21'h00010, 8'h00, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t3l_lat", lat, 1);
    chk("t3l_rd", rd, 8'h34);

    // 4: invalidate, and invalidate on the fill edge
    cache_inval = 1'b1;
    tick();
    cache_inval = 1'b0;
    req(0, 21'h00010, 8'h00, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t4_lat", lat, 5);
    chk("t4_oe", oe_n, 4);
    chk("t4_rd", rd, 8'h34);
    req(0, 21'h00012, 8'h00, 0, 4, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t4f_lat", lat, 5);
    chk("t4f_rd", rd, 8'h09);
    req(0, 21'h00013, 8'h00, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t4m_lat", lat, 5);
    chk("t4m_rd", rd, 8'hC0);

    // 5: reset in the middle of an access
    req(0, 21'h00011, 8'h00, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t5a_lat", lat, 5);
    chk("t5a_rd", rd, 8'h12);
    req(0, 21'h00010, 8'h00, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t5b_lat", lat, 1);
    rdy0        = n_rdy;
    bus_enable  = 1'b1;
    bus_write   = 1'b0;
    bus_address = 21'h00020;
    tick();
    tick();
    chk("t5_oe_mid", sd_oe, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_oe", sd_oe, 0);
    chk("t5_rst_we", sd_we, 0);
    chk("t5_rst_rdy", bus_ready, 0);
    chk("t5_rst_rd", bus_rdata, 0);
    tick();
    tick();
    bus_enable = 1'b0;
    reset      = 1'b0;
    tick();
    chk("t5_no_rdy", n_rdy - rdy0, 0);
    req(0, 21'h00011, 8'h00, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t5c_lat", lat, 5);
    chk("t5c_rd", rd, 8'h12);

    // 6: OR-bus zeroing and back-to-back requests
    req(0, 21'h00010, 8'h00, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t6_rd", rd, 8'h34);
    chk("t6_zero", bus_rdata, 8'h00);
    oe0  = n_oe;
    rdy0 = n_rdy;
    req(0, 21'h00030, 8'h00, 1, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t6a_lat", lat, 5);
    chk("t6a_rd", rd, 8'h18);
    req(0, 21'h00032, 8'h00, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("t6b_lat", lat, 6);
    chk("t6b_rd", rd, 8'h19);
    repeat (4) tick();
    chk("t6_oe_cnt", n_oe - oe0, 2);
    chk("t6_rdy_cnt", n_rdy - rdy0, 2);

    // top word address
    req(0, 21'h1FFFFF, 8'h00, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("top_addr", sa, 20'hFFFFF);
    chk("top_lat", lat, 5);
    chk("top_rd", rd, 8'hCF);
    req(0, 21'h1FFFFE, 8'h00, 0, -1, lat, oe_n, we_n, rd, ds, sa, din);
    chk("top_hit_lat", lat, 1);
    chk("top_hit_rd", rd, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
